button_conditioner: RTL
=======================

# button_conditioner

Front-end that turns the oven panel's raw, bouncing inputs into clean single-cycle commands for the countdown timer. It synchronises and debounces the two active-low set buttons and the run/set toggle, then emits increment/decrement pulses with hold-to-auto-repeat. It also emits a debounced run level with edge pulses. It sits between the board pins and the timer, replacing the timer's free-running slow button clock.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised input must differ from its stable value before the stable value changes (≥2).
- REPEAT_DELAY, 25000000: cycles a button must stay held after its first pulse before auto-repeat starts.
- REPEAT_RATE, 10000000: cycles between auto-repeat pulses.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- button1  input  1  raw increment button, active-low.
- button2  input  1  raw decrement button, active-low.
- toggle_set  input  1  raw switch; 0 = set mode, 1 = run.
- inc_pulse  output  1  one-cycle increment command.
- dec_pulse  output  1  one-cycle decrement command.
- run_level  output  1  debounced toggle_set.
- run_rise  output  1  one-cycle pulse on run_level 0→1.
- run_fall  output  1  one-cycle pulse on run_level 1→0.

## Operation

- Synchronisation: each raw input passes through a 2-flop synchroniser. Reset values are 1 for the buttons and 0 for the toggle.
- Debounce, per input:
  - The counter clears whenever the synchronised value equals the stable value.
  - Otherwise it increments. At DEBOUNCE_CYCLES−1 the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable value.
- Button FSM, one per button. States IDLE, DELAY, REPEAT, LOCK.
  - IDLE → DELAY on a stable press (1→0). The button's pulse fires and its counter clears.
  - DELAY → REPEAT when the counter reaches REPEAT_DELAY−1 while still held. A pulse fires and the counter clears.
  - REPEAT: a pulse fires every REPEAT_RATE cycles while held.
  - DELAY or REPEAT → IDLE on a stable release, with no pulse.
- Both buttons held (stable) simultaneously: both FSMs go to LOCK and no pulses are issued.
  - Both FSMs leave LOCK for IDLE only when both buttons are released.
  - If both presses become stable on the same cycle, neither pulses.
- Run interlock: while run_level=1, inc_pulse and dec_pulse are forced to 0. Button FSMs still track press/release.
  - A button already held when run_level falls produces no pulse until it is released and pressed again. Its FSM sits in LOCK.
- run_rise and run_fall fire on stable toggle transitions only.
- inc_pulse and dec_pulse are never both 1 in the same cycle.

## Timing

- All outputs are registered. Reset value of every output is 0. The asynchronous reset also clears all counters, sets FSMs to IDLE and sets stable values to released/0.
- Press latency: a raw low applied before edge k produces inc_pulse high for exactly the cycle after edge k+DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=4 that is 7 cycles.
- First auto-repeat pulse comes REPEAT_DELAY cycles after the first pulse. Subsequent pulses are spaced exactly REPEAT_RATE cycles apart.
- Release latency is DEBOUNCE_CYCLES+2 cycles. A repeat pulse due inside that window still fires.
- run_level latency is the same as press latency. run_rise/run_fall coincide with the first cycle of the new run_level.
- Reset asserted mid-hold: outputs drop immediately. After rst_n deasserts, a button still held is seen as a new press, giving one pulse after the debounce latency.
- Counter widths must hold the largest parameter. No wrap-around is permitted.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.

- Reset then idle 100 cycles with buttons=1 and toggle=0 → all outputs 0 throughout.
- button1 low for 3 cycles then high, repeated 10 times → no inc_pulse.
- button1 held low 60 cycles → inc_pulse at cycle 7, then at 27, 35, 43, 51, 59. Each pulse is exactly one cycle wide; dec_pulse stays 0.
- Both buttons low together for 40 cycles, then button2 released while button1 stays held → no pulses. After button2 is released, still no pulses until button1 is released and pressed again. That new press pulses after 7 cycles.
- toggle_set 0→1 with bounce (1/0 alternating every 2 cycles for 10 cycles, then steady 1) → exactly one run_rise, and run_level=1 stays stable afterwards. While it is 1, a button2 press gives no dec_pulse.
- button2 held, rst_n pulsed low for 3 cycles at cycle 30 → outputs 0 during reset. One dec_pulse 7 cycles after rst_n rises, then repeats resume on the 20/8 schedule.

Source files
------------

// File: rtl/button_conditioner.sv
// Panel input front-end: sync, debounce, press/auto-repeat pulses
// and run-mode level with edge pulses for the countdown timer.
module bc_debounce #(
  parameter int   DEB     = 4,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEB);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {2{RST_VAL}};
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module bc_button_fsm #(
  parameter int RD = 20,
  parameter int RR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,
  input  logic other_held,
  input  logic run,
  output logic pulse
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    LOCK
  } state_t;

  localparam int MX = (RD > RR) ? RD : RR;
  localparam int RW = $clog2(MX + 1);
  localparam logic [RW-1:0] RD_END = RW'(RD - 1);
  localparam logic [RW-1:0] RR_END = RW'(RR - 1);

  state_t        state;
  state_t        state_d;
  logic [RW-1:0] cnt;
  logic [RW-1:0] cnt_d;
  logic          fire;
  logic          lock;

  // A held button is frozen by the other button or by run mode
  assign lock = held && (other_held || run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pulse <= fire;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (lock)      state_d = LOCK;
        else if (held) state_d = DELAY;
      end
      DELAY: begin
        if (lock)                 state_d = LOCK;
        else if (!held)           state_d = IDLE;
        else if (cnt == RD_END)   state_d = REPEAT;
      end
      REPEAT: begin
        if (lock)       state_d = LOCK;
        else if (!held) state_d = IDLE;
      end
      LOCK: begin
        if (!held && !other_held) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire = 1'b0;
    unique case (state)
      IDLE:    fire = held && !lock;
      DELAY:   fire = held && !lock && (cnt == RD_END);
      REPEAT:  fire = held && !lock && (cnt == RR_END);
      default: fire = 1'b0;
    endcase
    if (fire)
      cnt_d = '0;
    else if (state_d == DELAY || state_d == REPEAT)
      cnt_d = cnt + 1'b1;
    else
      cnt_d = '0;
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button1,
  input  logic button2,
  input  logic toggle_set,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic run_level,
  output logic run_rise,
  output logic run_fall
);

  logic s1;
  logic s2;
  logic st;

  bc_debounce #(.DEB(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db1 (
    .clk(clk), .rst_n(rst_n), .raw(button1), .stable(s1)
  );
  bc_debounce #(.DEB(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db2 (
    .clk(clk), .rst_n(rst_n), .raw(button2), .stable(s2)
  );
  bc_debounce #(.DEB(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_dbt (
    .clk(clk), .rst_n(rst_n), .raw(toggle_set), .stable(st)
  );

  bc_button_fsm #(.RD(REPEAT_DELAY), .RR(REPEAT_RATE)) u_inc (
    .clk(clk), .rst_n(rst_n),
    .held(!s1), .other_held(!s2), .run(run_level),
    .pulse(inc_pulse)
  );
  bc_button_fsm #(.RD(REPEAT_DELAY), .RR(REPEAT_RATE)) u_dec (
    .clk(clk), .rst_n(rst_n),
    .held(!s2), .other_held(!s1), .run(run_level),
    .pulse(dec_pulse)
  );

  // Extra stage aligns run_level latency with the button pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_level <= 1'b0;
      run_rise  <= 1'b0;
      run_fall  <= 1'b0;
    end else begin
      run_level <= st;
      run_rise  <= st && !run_level;
      run_fall  <= !st && run_level;
    end
  end

endmodule
